dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, meaning the address width, matching the data memory address register.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the pixel word width.
REQ-003 The block SHALL have parameter DEPTH, default 2**19, meaning the number of implemented words, 1..2**ADDR_W.
REQ-004 The block SHALL have parameter RD_LAT, default 2, meaning read latency in cycles, 1..8.
REQ-005 Ports SHALL be:
- clk  in  1  -- the only clock; rising edge.
- RST  in  1  -- reset; synchronous, active-high.
- MEM_RD  in  1  -- read request.
- MEM_WR  in  1  -- write request.
- addr_in  in  ADDR_W  -- word address, driven from the data memory address register.
- data_in  in  DATA_W  -- write data.
- data_out  out  DATA_W  -- read data, held between reads.
- MEM_BUSY  out  1  -- a request is in progress.
- MEM_DONE  out  1  -- one-cycle completion pulse.

Function
REQ-006 The FSM SHALL have four states:
- IDLE: MEM_BUSY=0.
- RD_WAIT, WR, DONE: MEM_BUSY=1.
REQ-007 In IDLE, a rising edge with MEM_WR=1 SHALL accept a write and capture addr_in and data_in; the state SHALL go to WR.
REQ-008 In IDLE, a rising edge with MEM_RD=1 and MEM_WR=0 SHALL accept a read and capture addr_in; the state SHALL go to RD_WAIT.
REQ-009 If MEM_RD=1 and MEM_WR=1 on the same edge, the request SHALL be treated as a write and the read SHALL be dropped.
REQ-010 Requests presented while MEM_BUSY=1 SHALL be ignored. They SHALL not be queued.
REQ-011 Read timing, for a read accepted at edge k:
- data_out SHALL update at edge k+RD_LAT.
- DONE SHALL be entered at edge k+RD_LAT.
- A down-counter of width clog2(RD_LAT+1) SHALL count the RD_WAIT cycles.
REQ-012 Write timing, for a write accepted at edge k:
- RAM SHALL be written at edge k+1.
- DONE SHALL be entered at edge k+1.
REQ-013 DONE SHALL last exactly one cycle, with MEM_DONE=1. The state SHALL then return to IDLE. A new request SHALL be accepted no earlier than the edge that leaves DONE.
REQ-014 A captured address >= DEPTH SHALL be handled as follows:
- A read SHALL return all-zeros.
- A write SHALL be discarded.
- Timing and MEM_DONE SHALL be unchanged.
REQ-015 Address comparison SHALL be unsigned on ADDR_W bits with no wrap-around. Only addresses below DEPTH SHALL index the RAM.
REQ-016 data_out SHALL change only at read completion or reset. Writes SHALL never alter data_out, even to the same address.
REQ-017 A read of an address written by the immediately preceding write SHALL return the new data.

Reset
REQ-018 While RST=1 at a rising edge, the block SHALL go to IDLE with data_out=0, MEM_BUSY=0 and MEM_DONE=0, and the counter SHALL clear.
REQ-019 RST asserted mid-operation SHALL abort the operation with no MEM_DONE pulse. A write still in WR SHALL not commit.
REQ-020 RST SHALL not clear RAM contents.
REQ-021 RST SHALL have priority over any request on the same edge.

Structure
REQ-022 The shared package SHALL hold:
- the state enum (IDLE, RD_WAIT, WR, DONE),
- ADDR_W=19,
- DATA_W=8.
REQ-023 RAM storage SHALL be one sub-module, ram_sp: a single-port synchronous RAM with 1-cycle read and write-enable, DEPTH x DATA_W.
REQ-024 The FSM, counter and range check SHALL stay in dmem_responder.

Verification
REQ-025 Write/read:
- Stimulus: RST 2 cycles; write addr 0x00010, data 0xA5; after DONE, read 0x00010.
- Required: data_out=0xA5 and MEM_DONE 2 cycles after the read is accepted (RD_LAT=2).
REQ-026 Simultaneous request:
- Stimulus: MEM_RD=1 and MEM_WR=1 together at 0x7FFFF with data 0x3C.
- Required: treated as a write; a later read of 0x7FFFF returns 0x3C.
REQ-027 Request while busy:
- Stimulus: a write to 0x00020 (data 0x11) presented during RD_WAIT.
- Required: ignored; MEM_DONE pulses exactly once; a later read of 0x00020 returns the old value.
REQ-028 Out-of-range access:
- Stimulus: DEPTH=1024; write 0xFF to 0x00400, then read 0x00400.
- Required: data_out=0x00 with a MEM_DONE pulse; a read of 0x00000 is unaffected.
REQ-029 Reset mid-write:
- Stimulus: RST in the WR cycle of a write of 0x99 to 0x00005, which previously held 0x22.
- Required: no MEM_DONE pulse; data_out=0; a later read of 0x00005 returns 0x22.
REQ-030 Latency sweep:
- Stimulus: RD_LAT=1 and RD_LAT=8.
- Required: MEM_DONE exactly RD_LAT cycles after accept; MEM_BUSY high for RD_LAT+1 cycles.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder: default address and
// data widths, the controller state encoding, and a helper that sizes the
// RAM index for a given number of implemented words.
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR      = 2'd2,
      DONE    = 2'd3
   } state_e;

   // Index width for a RAM of 'depth' words; a one-word RAM still needs a
   // one-bit index so the port never collapses to zero width.
   function automatic int ram_addr_w(input int depth);
      return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
   endfunction

endpackage

// File: rtl/dmem_responder_ram_sp.sv
// ---------------------------------------------------------------------------
// ram_sp
// Single-port synchronous RAM, DEPTH x DATA_W. Read data is registered and
// appears one cycle after the address is presented; a write takes effect on
// the edge where we_i is high. Contents have no reset.
//
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   addr_i   in   word index (AW bits)
//   wdata_i  in   write data
//   rdata_o  out  registered read data (old contents on a write cycle)
// ---------------------------------------------------------------------------
module ram_sp #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 8,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage write port and registered read port sharing one address.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Handshake responder in front of a single-port data memory. A request is
// accepted only in IDLE; a write commits one cycle after acceptance, a read
// completes RD_LAT cycles after acceptance. Each completed request gives one
// MEM_DONE pulse. Addresses at or above DEPTH read as zero and drop writes
// with unchanged timing.
//
// Ports:
//   clk       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   MEM_RD    in   read request
//   MEM_WR    in   write request (wins over MEM_RD on the same edge)
//   addr_in   in   word address
//   data_in   in   write data
//   data_out  out  read data, held until the next read completes
//   MEM_BUSY  out  a request is in progress
//   MEM_DONE  out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_W = dmem_responder_pkg::ADDR_W,
   parameter int DATA_W = dmem_responder_pkg::DATA_W,
   parameter int DEPTH  = 2 ** ADDR_W,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              MEM_RD,
   input  logic              MEM_WR,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              MEM_BUSY,
   output logic              MEM_DONE
);

   import dmem_responder_pkg::*;

   localparam int RAM_AW = ram_addr_w(DEPTH);
   localparam int CNT_W  = $clog2(RD_LAT + 1);
   // One extra bit so DEPTH == 2**ADDR_W is representable and the compare
   // never wraps.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   state_e              state_q;
   logic [RAM_AW-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   data_out_q;
   logic                in_range_q;
   logic                busy_q;
   logic                done_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                ram_we_s;
   logic [RAM_AW-1:0]   ram_addr_s;
   logic [DATA_W-1:0]   ram_rdata_s;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_W);
   endfunction

   // RAM port control. In IDLE the incoming address is presented directly so
   // read data is already valid one edge after acceptance, which is what lets
   // RD_LAT=1 work. The write is suppressed by reset and by an out-of-range
   // captured address.
   always_comb begin
      ram_addr_s = addr_q;
      ram_we_s   = 1'b0;
      if (state_q == IDLE) begin
         ram_addr_s = addr_in[RAM_AW-1:0];
      end else begin
         ram_addr_s = addr_q;
      end
      if ((state_q == WR) && in_range_q && !RST) begin
         ram_we_s = 1'b1;
      end else begin
         ram_we_s = 1'b0;
      end
   end

   ram_sp #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .addr_i  (ram_addr_s),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata_s)
   );

   // Request FSM with latency counter and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q    <= IDLE;
         addr_q     <= {RAM_AW{1'b0}};
         wdata_q    <= {DATA_W{1'b0}};
         data_out_q <= {DATA_W{1'b0}};
         in_range_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (MEM_WR) begin
                  state_q    <= WR;
                  addr_q     <= addr_in[RAM_AW-1:0];
                  wdata_q    <= data_in;
                  in_range_q <= addr_in_range(addr_in);
                  busy_q     <= 1'b1;
               end else if (MEM_RD) begin
                  state_q    <= RD_WAIT;
                  addr_q     <= addr_in[RAM_AW-1:0];
                  in_range_q <= addr_in_range(addr_in);
                  busy_q     <= 1'b1;
                  // RD_WAIT spans RD_LAT edges; the last one sees zero.
                  cnt_q      <= CNT_W'(RD_LAT - 1);
               end else begin
                  state_q <= IDLE;
               end
            end
            RD_WAIT: begin
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  data_out_q <= in_range_q ? ram_rdata_s : {DATA_W{1'b0}};
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            WR: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out = data_out_q;
   assign MEM_BUSY = busy_q;
   assign MEM_DONE = done_q;

endmodule
